restoring_divider16: RTL and testbench
======================================

RESTORING_DIVIDER16 -- requirements
Module: restoring_divider16

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; all values below assume 16.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 Dividend  input  16  unsigned numerator; sampled on accepted Start.
REQ-006 Divisor  input  16  unsigned denominator; sampled on accepted Start.
REQ-007 Quotient  output  16  registered unsigned quotient.
REQ-008 Remainder  output  16  registered unsigned remainder.
REQ-009 Busy  output  1  high while state is CALC.
REQ-010 Done  output  1  high for exactly one cycle when state is DONE.
REQ-011 DivByZero  output  1  registered flag: last accepted operation had Divisor == 0.

Function
REQ-012 FSM states: IDLE, CALC, DONE; outputs Busy/Done decoded from the state register only.
REQ-013 IDLE, Start=1, Divisor!=0 at edge k -> latch Dividend into working quotient Q, clear working remainder R, counter=0, DivByZero=0, go CALC.
REQ-014 IDLE, Start=1, Divisor==0 at edge k -> Quotient=0xFFFF, Remainder=Dividend, DivByZero=1, go DONE (Done high in cycle after edge k).
REQ-015 IDLE, Start=0 -> remain IDLE; Quotient/Remainder/DivByZero hold.
REQ-016 CALC, one iteration per edge: T = {R,Q[15]} - {1'b0,Divisor} (17-bit); T non-negative -> R=T[15:0], Q={Q[14:0],1}; else R={R[14:0],Q[15]}, Q={Q[14:0],0}.
REQ-017 Counter increments each CALC edge; the edge performing iteration 16 (counter==15) writes final Q/R to Quotient/Remainder and goes DONE.
REQ-018 Latency: Start accepted at edge k -> Done high during the cycle following edge k+16; Busy high during cycles following edges k..k+15.
REQ-019 DONE -> IDLE unconditionally at next edge; Done deasserts; results hold until next accepted Start.
REQ-020 Start while CALC or DONE is ignored; operands not resampled; operation unaffected.
REQ-021 Quotient/Remainder outputs unchanged during CALC (update only on the REQ-017 edge or REQ-014 edge).
REQ-022 Arithmetic unsigned; Quotient*Divisor+Remainder == Dividend and Remainder < Divisor for all Divisor != 0.
REQ-023 Start held high continuously -> new operation accepted every 18 cycles (IDLE, 16 CALC, DONE).

Reset
REQ-024 Reset=1 at an edge -> state IDLE, counter=0, Quotient=0, Remainder=0, DivByZero=0, Busy=0, Done=0.
REQ-025 Reset has priority over Start and over any in-progress CALC/DONE; aborted operation produces no Done and no output update.
REQ-026 Start sampled in the same edge as Reset=1 is discarded.

Verification
REQ-027 Dividend=100, Divisor=7, Start pulse at edge k -> Busy 16 cycles, Done one cycle after edge k+16, Quotient=14, Remainder=2, DivByZero=0.
REQ-028 Dividend=0xFFFF, Divisor=1 -> Quotient=0xFFFF, Remainder=0; Dividend=0xFFFF, Divisor=0xFFFF -> Quotient=1, Remainder=0.
REQ-029 Dividend=3, Divisor=10 -> Quotient=0, Remainder=3; Dividend=0, Divisor=5 -> Quotient=0, Remainder=0.
REQ-030 Dividend=5, Divisor=0 -> Done in cycle after accepting edge, Quotient=0xFFFF, Remainder=5, DivByZero=1, Busy never asserted.
REQ-031 Start 1234/10 then Start 9/3 pulsed during CALC -> second Start ignored; Quotient=123, Remainder=4.
REQ-032 Reset asserted at CALC iteration 8 -> next cycle IDLE, all outputs 0, no Done; new 50/6 afterwards -> Quotient=8, Remainder=2.

Source files
------------

// File: rtl/restoring_divider16_if.sv
// Divider request/result bundle.
//   master (requester): drives start, dividend, divisor; observes results and status.
//   slave  (divider):   samples the request; drives quotient, remainder, busy, done, div_by_zero.
interface restoring_divider16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/restoring_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - synchronous active-high reset
//   div_if - slave side of restoring_divider16_if
//            (start/dividend/divisor in; quotient/remainder/busy/done/div_by_zero out)
// A start accepted in IDLE yields done one cycle after the 16th CALC edge.
// Divisor zero short-circuits straight to DONE with quotient all-ones and
// remainder equal to the dividend.
module restoring_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  restoring_divider16_if.slave div_if
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wq_q, wq_d;     // working quotient, dividend shifts out of its MSB
  logic [WIDTH-1:0] wr_q, wr_d;     // working partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor captured at start
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] q_next_c;
  logic [WIDTH-1:0] r_next_c;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wq_q    <= '0;
      wr_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wq_q    <= wq_d;
      wr_q    <= wr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wq_d    = wq_q;
    wr_d    = wr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // Partial remainder stays below the divisor, so bit WIDTH of the
    // trial difference is a reliable borrow (negative) flag.
    trial_c = {wr_q, wq_q[WIDTH-1]} - {1'b0, dvs_q};
    if (trial_c[WIDTH]) begin
      r_next_c = {wr_q[WIDTH-2:0], wq_q[WIDTH-1]};
      q_next_c = {wq_q[WIDTH-2:0], 1'b0};
    end else begin
      r_next_c = trial_c[WIDTH-1:0];
      q_next_c = {wq_q[WIDTH-2:0], 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (div_if.start) begin
          dvs_d = div_if.divisor;
          if (div_if.divisor == '0) begin
            quo_d   = '1;
            rem_d   = div_if.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            wq_d    = div_if.dividend;
            wr_d    = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        wq_d  = q_next_c;
        wr_d  = r_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_next_c;
          rem_d   = r_next_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_if.quotient    = quo_q;
  assign div_if.remainder   = rem_q;
  assign div_if.div_by_zero = dbz_q;
  assign div_if.busy        = (state_q == CALC);
  assign div_if.done        = (state_q == DONE);

endmodule

// File: tb/tb_restoring_divider16.sv
// Scoreboard bench for restoring_divider16: expected results are queued when
// a request is driven and compared when done is observed.
module tb_restoring_divider16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  restoring_divider16_if #(.WIDTH(16)) div_if ();

  restoring_divider16 #(.WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // One-cycle start pulse; leaves the bench at the negedge after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    div_if.start = 1'b0;
  endtask

  // Bounded wait for done; reports cycles waited, busy cycles seen and
  // whether quotient/remainder stayed put while waiting.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit stable);
    logic [15:0] q0, r0;
    q0 = div_if.quotient;
    r0 = div_if.remainder;
    cycles = 0; busy_cnt = 0; stable = 1'b1;
    while (div_if.done !== 1'b1 && cycles < 40) begin
      if (div_if.busy === 1'b1) busy_cnt++;
      if (div_if.quotient !== q0 || div_if.remainder !== r0) stable = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({div_if.busy, div_if.done, div_if.div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b expected 000",
               {div_if.busy, div_if.done, div_if.div_by_zero});
    end
    checks++;
    if (div_if.quotient !== 16'd0 || div_if.remainder !== 16'd0) begin
      errors++;
      $display("FAIL reset_results: q=%0d r=%0d expected 0/0", div_if.quotient, div_if.remainder);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, bc; bit st; exp_t e;
    start_op(16'd100, 16'd7);
    wait_done(cyc, bc, st);
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 16", cyc); end
    checks++;
    if (bc != 16) begin errors++; $display("FAIL basic_busy: busy %0d cycles expected 16", bc); end
    checks++;
    if (!st) begin errors++; $display("FAIL basic_hold: outputs changed during CALC, got 1 expected 0"); end
    e = exp_q.pop_front();
    checks++;
    if ({div_if.quotient, div_if.remainder, div_if.div_by_zero} !== {e.q, e.r, e.dbz}) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
               div_if.quotient, div_if.remainder, div_if.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (div_if.done !== 1'b0 || div_if.quotient !== 16'd14 || div_if.remainder !== 16'd2) begin
      errors++;
      $display("FAIL basic_after: done=%b q=%0d r=%0d expected 0 14 2",
               div_if.done, div_if.quotient, div_if.remainder);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] tbl_a [6];
    logic [15:0] tbl_b [6];
    int cyc, bc; bit st; exp_t e;
    tbl_a = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd0, 16'h8000, 16'hFFFE};
    tbl_b = '{16'd1, 16'hFFFF, 16'd10, 16'd5, 16'h8001, 16'h7FFF};
    for (int i = 0; i < 6; i++) begin
      start_op(tbl_a[i], tbl_b[i]);
      wait_done(cyc, bc, st);
      e = exp_q.pop_front();
      checks++;
      if (cyc != 16 || {div_if.quotient, div_if.remainder, div_if.div_by_zero} !== {e.q, e.r, e.dbz}) begin
        errors++;
        $display("FAIL boundary_%0d: %0d/%0d cyc=%0d q=%0d r=%0d dbz=%b expected cyc=16 q=%0d r=%0d dbz=%b",
                 i, tbl_a[i], tbl_b[i], cyc, div_if.quotient, div_if.remainder,
                 div_if.div_by_zero, e.q, e.r, e.dbz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int cyc, bc; bit st; exp_t e;
    start_op(16'd5, 16'd0);
    wait_done(cyc, bc, st);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 0 || bc != 0 || div_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_timing: cyc=%0d busy_cycles=%0d busy=%b expected 0 0 0", cyc, bc, div_if.busy);
    end
    checks++;
    if ({div_if.quotient, div_if.remainder, div_if.div_by_zero} !== {e.q, e.r, e.dbz}) begin
      errors++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b expected q=%h r=%0d dbz=%b",
               div_if.quotient, div_if.remainder, div_if.div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (div_if.done !== 1'b0 || div_if.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: done=%b dbz=%b expected 0 1", div_if.done, div_if.div_by_zero);
    end
    start_op(16'd9, 16'd4);
    checks++;
    if (div_if.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: dbz=%b expected 0", div_if.div_by_zero);
    end
    wait_done(cyc, bc, st);
    e = exp_q.pop_front();
    checks++;
    if ({div_if.quotient, div_if.remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL dbz_next: q=%0d r=%0d expected %0d %0d", div_if.quotient, div_if.remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc, bc; bit st; exp_t e; int extra;
    start_op(16'd1234, 16'd10);
    repeat (3) @(negedge clk);
    div_if.start    = 1'b1;
    div_if.dividend = 16'd9;
    div_if.divisor  = 16'd3;
    @(negedge clk);
    div_if.start = 1'b0;
    wait_done(cyc, bc, st);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 12 || div_if.quotient !== 16'd123 || div_if.remainder !== 16'd4 ||
        div_if.quotient !== e.q || div_if.remainder !== e.r) begin
      errors++;
      $display("FAIL ignored_start: cyc=%0d q=%0d r=%0d expected cyc=12 q=123 r=4",
               cyc, div_if.quotient, div_if.remainder);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (div_if.done === 1'b1 || div_if.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_no_second: %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bc; bit st; exp_t e; int active;
    start_op(16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    rst             = 1'b1;
    div_if.start    = 1'b1;
    div_if.dividend = 16'd50;
    div_if.divisor  = 16'd6;
    @(negedge clk);
    rst          = 1'b0;
    div_if.start = 1'b0;
    exp_q.delete();
    checks++;
    if ({div_if.busy, div_if.done, div_if.div_by_zero, div_if.quotient, div_if.remainder} !== 35'd0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
               div_if.busy, div_if.done, div_if.div_by_zero, div_if.quotient, div_if.remainder);
    end
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_if.done === 1'b1 || div_if.busy === 1'b1) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles expected 0", active);
    end
    start_op(16'd50, 16'd6);
    wait_done(cyc, bc, st);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 16 || div_if.quotient !== 16'd8 || div_if.remainder !== 16'd2 ||
        div_if.quotient !== e.q || div_if.remainder !== e.r) begin
      errors++;
      $display("FAIL abort_recover: cyc=%0d q=%0d r=%0d expected cyc=16 q=8 r=2",
               cyc, div_if.quotient, div_if.remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n; exp_t e; int extra;
    div_if.dividend = 16'd40000;
    div_if.divisor  = 16'd123;
    div_if.start    = 1'b1;
    exp_q.push_back(model(16'd40000, 16'd123));
    exp_q.push_back(model(16'd40000, 16'd123));
    n = 0;
    do begin @(negedge clk); n++; end while (div_if.done !== 1'b1 && n < 40);
    e = exp_q.pop_front();
    checks++;
    if (n != 17 || {div_if.quotient, div_if.remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL b2b_first: n=%0d q=%0d r=%0d expected n=17 q=%0d r=%0d",
               n, div_if.quotient, div_if.remainder, e.q, e.r);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (div_if.done !== 1'b1 && n < 40);
    div_if.start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (n != 18 || {div_if.quotient, div_if.remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL b2b_period: n=%0d q=%0d r=%0d expected n=18 q=%0d r=%0d",
               n, div_if.quotient, div_if.remainder, e.q, e.r);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (div_if.done === 1'b1 || div_if.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_stop: %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_random();
    int cyc, bc; bit st; exp_t e;
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535)) >> $urandom_range(0, 15);
      if (b == 16'd0) b = 16'd1;
      start_op(a, b);
      wait_done(cyc, bc, st);
      e = exp_q.pop_front();
      checks++;
      if (cyc != 16 || {div_if.quotient, div_if.remainder, div_if.div_by_zero} !== {e.q, e.r, e.dbz}) begin
        errors++;
        $display("FAIL random_%0d: %0d/%0d cyc=%0d q=%0d r=%0d expected cyc=16 q=%0d r=%0d",
                 i, a, b, cyc, div_if.quotient, div_if.remainder, e.q, e.r);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    div_if.start    = 1'b0;
    div_if.dividend = 16'd0;
    div_if.divisor  = 16'd0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
